// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding selects, hazard stall detection and multicycle-result scoreboard
// Selects and stall are combinational; only the scoreboard and the stall counter hold state.
module fwd_hazard_unit #(
    parameter int RAW      = 5,
    parameter int MD_SLOTS = 2,
    parameter int MD_LW    = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RAW-1:0]   id_rs,
    input  logic [RAW-1:0]   id_rt,
    input  logic             id_branch,
    input  logic [RAW-1:0]   ex_rs,
    input  logic [RAW-1:0]   ex_rt,
    input  logic [RAW-1:0]   ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [RAW-1:0]   mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [RAW-1:0]   wb_rd,
    input  logic             wb_regwrite,
    input  logic             md_issue,
    input  logic [RAW-1:0]   md_rd,
    input  logic [MD_LW-1:0] md_lat,
    output logic [1:0]       fwd_a_alu,
    output logic [1:0]       fwd_b_alu,
    output logic [1:0]       fwd_a_eq,
    output logic [1:0]       fwd_b_eq,
    output logic             stall,
    output logic             md_full,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int IW = MD_SLOTS > 1 ? $clog2(MD_SLOTS) : 1;

    function automatic logic [1:0] fwdSel(input logic [RAW-1:0] src, input logic [RAW-1:0] mRd,
                                          input logic mWr, input logic [RAW-1:0] wRd, input logic wWr);
        return (mWr && mRd != '0 && mRd == src) ? 2'b10 :
               (wWr && wRd != '0 && wRd == src) ? 2'b01 : 2'b00;
    endfunction

    assign fwd_a_alu = fwdSel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    assign fwd_b_alu = fwdSel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    assign fwd_a_eq  = id_branch ? fwdSel(id_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;
    assign fwd_b_eq  = id_branch ? fwdSel(id_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite) : 2'b00;

    logic [MD_SLOTS-1:0] slotValid;
    logic [RAW-1:0]      slotRd  [MD_SLOTS];
    logic [MD_LW-1:0]    slotCnt [MD_SLOTS];

    logic [MD_SLOTS-1:0] expiring;
    logic                sbHit, wawHit, freeFound;
    logic [IW-1:0]       wawIdx, freeIdx;

    always_comb begin
        expiring  = '0;
        sbHit     = 1'b0;
        wawHit    = 1'b0;
        freeFound = 1'b0;
        wawIdx    = '0;
        freeIdx   = '0;
        for (int i = 0; i < MD_SLOTS; i++) begin
            expiring[i] = slotValid[i] && slotCnt[i] <= MD_LW'(1);
            sbHit = sbHit | (slotValid[i] && (slotRd[i] == id_rs || slotRd[i] == id_rt));
            if (slotValid[i] && slotRd[i] == md_rd) begin
                wawHit = 1'b1;
                wawIdx = IW'(i);
            end
            if (!freeFound && (!slotValid[i] || expiring[i])) begin
                freeFound = 1'b1;
                freeIdx   = IW'(i);
            end
        end
    end

    logic loadUse, branchEx, branchMem;
    assign loadUse   = ex_memread && ex_rd != '0 && (ex_rd == id_rs || ex_rd == id_rt);
    assign branchEx  = id_branch && ex_regwrite && ex_rd != '0 && (ex_rd == id_rs || ex_rd == id_rt);
    assign branchMem = id_branch && mem_memread && mem_rd != '0 && (mem_rd == id_rs || mem_rd == id_rt);
    // An expiring slot counts as free: its result is in MEM/WB next cycle anyway.
    assign md_full   = &(slotValid & ~expiring);
    assign stall     = loadUse || branchEx || branchMem || sbHit || (md_issue && md_full);

    logic             alloc;
    logic [IW-1:0]    allocIdx;
    logic [MD_LW-1:0] allocLat;
    assign alloc    = md_issue && md_rd != '0 && !stall && (wawHit || freeFound);
    assign allocIdx = wawHit ? wawIdx : freeIdx;
    assign allocLat = md_lat == '0 ? MD_LW'(1) : md_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotValid <= '0;
            stall_cnt <= '0;
            for (int i = 0; i < MD_SLOTS; i++) begin
                slotRd[i]  <= '0;
                slotCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MD_SLOTS; i++) begin
                if (alloc && allocIdx == IW'(i)) begin
                    slotValid[i] <= 1'b1;
                    slotRd[i]    <= md_rd;
                    slotCnt[i]   <= allocLat;
                end else if (slotValid[i]) begin
                    slotValid[i] <= !expiring[i];
                    slotCnt[i]   <= slotCnt[i] - MD_LW'(1);
                end
            end
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vectors queued as expectations, checked by an independent negedge monitor.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd, md_rd;
    logic id_branch, ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, md_issue;
    logic [5:0] md_lat;
    logic [1:0] fwd_a_alu, fwd_b_alu, fwd_a_eq, fwd_b_eq;
    logic stall, md_full;
    logic [31:0] stall_cnt;

    fwd_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_branch(id_branch),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .md_issue(md_issue), .md_rd(md_rd), .md_lat(md_lat),
        .fwd_a_alu(fwd_a_alu), .fwd_b_alu(fwd_b_alu), .fwd_a_eq(fwd_a_eq), .fwd_b_eq(fwd_b_eq),
        .stall(stall), .md_full(md_full), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // vec layout: {fwd_a_alu, fwd_b_alu, fwd_a_eq, fwd_b_eq, stall, md_full}
    typedef struct {
        string       tag;
        logic [9:0]  vec;
        logic [9:0]  mask;
        logic [31:0] cnt;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  nStall = 0;

    initial forever begin
        @(negedge clk);
        while (expQ.size() > 0) begin
            expT x;
            logic [9:0] obs;
            x   = expQ.pop_front();
            obs = {fwd_a_alu, fwd_b_alu, fwd_a_eq, fwd_b_eq, stall, md_full};
            checks++;
            if (((obs ^ x.vec) & x.mask) != 10'b0) begin
                errors++;
                $display("FAIL %s: outputs=%b expected=%b (mask %b)", x.tag, obs, x.vec, x.mask);
            end
            checks++;
            if (stall_cnt !== x.cnt) begin
                errors++;
                $display("FAIL %s_cnt: stall_cnt=%0d expected=%0d", x.tag, stall_cnt, x.cnt);
            end
        end
    end

    task automatic idle();
        {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd, md_rd} = '0;
        {id_branch, ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, md_issue} = '0;
        md_lat = '0;
    endtask

    // Queue this cycle's expectation (stall_cnt reflects earlier stalls), then advance one clock.
    task automatic cyc(input string tag, input logic [9:0] e, input logic [9:0] m = 10'h3FF);
        expT x;
        x.tag  = tag;
        x.vec  = e;
        x.mask = m;
        x.cnt  = nStall;
        expQ.push_back(x);
        nStall += int'(e[1]);
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        cyc("reset", 10'b00_00_00_00_0_0);
        rst_n = 1'b1;

        mem_rd = 3; mem_regwrite = 1; wb_rd = 3; wb_regwrite = 1; ex_rs = 3;
        cyc("prio_exmem", 10'b10_00_00_00_0_0);
        mem_rd = 3; wb_rd = 3; wb_regwrite = 1; ex_rt = 3;
        cyc("fwd_memwb", 10'b00_01_00_00_0_0);
        mem_rd = 0; mem_regwrite = 1; wb_rd = 0; wb_regwrite = 1;
        cyc("rd0_nofwd", 10'b00_00_00_00_0_0);
        ex_memread = 1; ex_rd = 5; id_rt = 5;
        cyc("load_use", 10'b00_00_00_00_1_0);
        cyc("load_use_after", 10'b00_00_00_00_0_0);
        ex_memread = 1; ex_rd = 0;
        cyc("load_use_rd0", 10'b00_00_00_00_0_0);
        id_branch = 1; ex_regwrite = 1; ex_rd = 7; id_rs = 7;
        cyc("branch_ex", 10'b00_00_00_00_1_0);
        id_branch = 1; id_rs = 7; mem_rd = 7; mem_regwrite = 1;
        cyc("branch_mem_fwd", 10'b00_00_10_00_0_0);
        id_branch = 1; id_rt = 8; mem_rd = 8; mem_regwrite = 1; mem_memread = 1;
        cyc("branch_load_mem", 10'b00_00_00_10_1_0);
        id_branch = 1; id_rt = 8; wb_rd = 8; wb_regwrite = 1;
        cyc("branch_wb_fwd", 10'b00_00_00_01_0_0);
        id_rs = 7; mem_rd = 7; mem_regwrite = 1;
        cyc("eq_forced_off", 10'b00_00_00_00_0_0);

        md_issue = 1; md_rd = 9; md_lat = 4;
        cyc("md_issue9", 10'b00_00_00_00_0_0);
        for (int i = 0; i < 4; i++) begin
            id_rs = 9; mem_rd = 9; mem_regwrite = 1;
            cyc($sformatf("md_wait%0d", i), 10'b00_00_00_00_1_0);
        end
        id_rs = 9;
        cyc("md_done", 10'b00_00_00_00_0_0);

        md_issue = 1; md_rd = 4; md_lat = 10;
        cyc("md_issue4", 10'b00_00_00_00_0_0);
        md_issue = 1; md_rd = 6; md_lat = 3;
        cyc("md_issue6", 10'b00_00_00_00_0_0);
        md_issue = 1; md_rd = 7; md_lat = 5;
        cyc("md_struct", 10'b00_00_00_00_1_1);
        cyc("md_full_hold", 10'b00_00_00_00_0_1);
        cyc("md_expiring", 10'b00_00_00_00_0_0);
        id_rs = 7;
        cyc("md_no_alloc7", 10'b00_00_00_00_0_0);
        md_issue = 1; md_rd = 4; md_lat = 8;
        cyc("md_waw4", 10'b00_00_00_00_0_0);
        md_issue = 1; md_rd = 11; md_lat = 20;
        cyc("md_issue11", 10'b00_00_00_00_0_0);
        for (int i = 0; i < 5; i++) begin
            id_rs = 4;
            cyc($sformatf("md_reload%0d", i), 10'b00_00_00_00_1_1);
        end

        rst_n = 1'b0;
        nStall = 0;
        id_rs = 4; id_rt = 11;
        cyc("mid_reset", 10'b00_00_00_00_0_0);
        rst_n = 1'b1;
        id_rs = 4; id_rt = 11;
        cyc("post_reset", 10'b00_00_00_00_0_0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        if (expQ.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
